// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and constants for the dispatch/rename controller.
//   disp_state_t : dispatch FSM state (RUN, WAIT_CTRL)
//   Q_*          : bit position of each issue queue in the one-hot queue select
//   st_entry_t   : register status table entry (pending flag + producing tag)
package dispatch_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_CTRL = 1'b1
  } disp_state_t;

  localparam int Q_INT  = 0;
  localparam int Q_MULT = 1;
  localparam int Q_DIV  = 2;
  localparam int Q_MEM  = 3;

  // Packages cannot be parametrised, so the stored tag field is sized for the
  // largest tag space we expect (256 tags); the top casts to/from TAG_W.
  localparam int ST_TAG_W = 8;

  typedef struct packed {
    logic                valid;
    logic [ST_TAG_W-1:0] tag;
  } st_entry_t;

endpackage

// File: rtl/tag_free_list.sv
// tag_free_list: circular FIFO of free physical tags.
//   clk, rst   : clock, synchronous active-high reset (refills with 0..NUM_TAGS-1)
//   pop        : consume head_tag this cycle
//   push       : return push_tag to the tail this cycle
//   head_tag   : next tag to hand out
//   count      : number of free tags (0..NUM_TAGS)
//   overflow   : sticky, set when a push arrives with no room
module tag_free_list #(
  parameter int NUM_TAGS = 64,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W:0]   count,
  output logic             overflow
);

  logic [TAG_W-1:0] mem [NUM_TAGS];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == (TAG_W+1)'(NUM_TAGS));
  assign do_pop   = pop & (count != '0);
  // A simultaneous pop frees the slot, so a push into a full list is kept.
  assign do_push  = push & (~full | do_pop);
  assign head_tag = mem[head];

  // NUM_TAGS is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= TAG_W'(i);
      head     <= '0;
      tail     <= '0;
      count    <= (TAG_W+1)'(NUM_TAGS);
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_tag;
        tail      <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_rename_ctrl.sv
// dispatch_rename_ctrl: dispatches the IFQ head into one of NUM_QUEUES issue
// queues, renames rd from the tag free-list, tracks pending registers in the
// status table, clears them on CDB broadcast and stalls behind branch/jalr.
//   IFQ/decoder : ifq_valid, ifq_rd, dec_queue_sel, dec_reg_write, dec_branch,
//                 dec_jalr, rd, rs1, rs2
//   issue queues: queue_full, queue_en
//   rename      : rs1/rs2_tag, rs1/rs2_tag_valid, rs1/rs2_fwd, rd_tag, rd_tag_valid
//   CDB         : cdb_valid, cdb_tag, cdb_branch, cdb_jalr
//   reg file    : rf_we, rf_rd
//   status      : free_count, ctrl_wait, fl_overflow
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | dispatching normally
// WAIT_CTRL | branch/jalr in flight; dispatch held until it resolves on CDB
module dispatch_rename_ctrl
  import dispatch_pkg::*;
#(
  parameter int NUM_QUEUES    = 4,
  parameter int NUM_TAGS      = 64,
  parameter int TAG_W         = $clog2(NUM_TAGS),
  parameter int NUM_ARCH_REGS = 32,
  parameter int REG_W         = $clog2(NUM_ARCH_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifq_valid,
  output logic                  ifq_rd,
  input  logic [NUM_QUEUES-1:0] dec_queue_sel,
  input  logic                  dec_reg_write,
  input  logic                  dec_branch,
  input  logic                  dec_jalr,
  input  logic [REG_W-1:0]      rd,
  input  logic [REG_W-1:0]      rs1,
  input  logic [REG_W-1:0]      rs2,
  input  logic [NUM_QUEUES-1:0] queue_full,
  output logic [NUM_QUEUES-1:0] queue_en,
  output logic [TAG_W-1:0]      rs1_tag,
  output logic [TAG_W-1:0]      rs2_tag,
  output logic                  rs1_tag_valid,
  output logic                  rs2_tag_valid,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_tag_valid,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic                  cdb_branch,
  input  logic                  cdb_jalr,
  output logic                  rf_we,
  output logic [REG_W-1:0]      rf_rd,
  output logic [TAG_W:0]        free_count,
  output logic                  ctrl_wait,
  output logic                  fl_overflow
);

  disp_state_t state;
  disp_state_t state_nxt;
  st_entry_t   st [NUM_ARCH_REGS];
  logic        need_tag;
  logic        dispatch;

  assign need_tag = dec_reg_write & (rd != '0);

  // ~rst keeps every strobe low while reset is held.
  assign dispatch = ~rst & ifq_valid & (state == RUN) & (|dec_queue_sel)
                  & ~(|(dec_queue_sel & queue_full))
                  & (~need_tag | (free_count != '0));

  assign ifq_rd       = dispatch;
  assign queue_en     = dec_queue_sel & {NUM_QUEUES{dispatch}};
  assign rd_tag_valid = dispatch & need_tag;
  assign ctrl_wait    = (state == WAIT_CTRL);

  tag_free_list #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (rd_tag_valid),
    .push     (cdb_valid),
    .push_tag (cdb_tag),
    .head_tag (rd_tag),
    .count    (free_count),
    .overflow (fl_overflow)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (dispatch & (dec_branch | dec_jalr)) state_nxt = WAIT_CTRL;
      WAIT_CTRL: if (cdb_branch | cdb_jalr)              state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // Sources see the table as it stood before this cycle's rename; x0 is
  // never written so it always reads not-pending.
  assign rs1_tag_valid = (rs1 != '0) & st[rs1].valid;
  assign rs2_tag_valid = (rs2 != '0) & st[rs2].valid;
  assign rs1_tag       = TAG_W'(st[rs1].tag);
  assign rs2_tag       = TAG_W'(st[rs2].tag);
  assign rs1_fwd       = rs1_tag_valid & cdb_valid & (rs1_tag == cdb_tag);
  assign rs2_fwd       = rs2_tag_valid & cdb_valid & (rs2_tag == cdb_tag);

  // Tags are unique, so at most one entry can match the broadcast.
  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    if (cdb_valid & ~rst) begin
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
        if (st[i].valid && (st[i].tag == ST_TAG_W'(cdb_tag))) begin
          rf_we = 1'b1;
          rf_rd = REG_W'(i);
        end
      end
    end
  end

  // A rename of the same register beats the CDB clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) st[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
        if (rd_tag_valid && (rd == REG_W'(i))) begin
          st[i].valid <= 1'b1;
          st[i].tag   <= ST_TAG_W'(rd_tag);
        end else if (rf_we && (rf_rd == REG_W'(i))) begin
          st[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_rename_ctrl.sv
module tb_dispatch_rename_ctrl;
  import dispatch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifq_valid, ifq_rd;
  logic [3:0] dec_queue_sel, queue_full, queue_en;
  logic       dec_reg_write, dec_branch, dec_jalr;
  logic [4:0] rd, rs1, rs2, rf_rd;
  logic [5:0] rs1_tag, rs2_tag, rd_tag, cdb_tag;
  logic       rs1_tag_valid, rs2_tag_valid, rs1_fwd, rs2_fwd, rd_tag_valid;
  logic       cdb_valid, cdb_branch, cdb_jalr, rf_we, ctrl_wait, fl_overflow;
  logic [6:0] free_count;

  dispatch_rename_ctrl dut (
    .clk(clk), .rst(rst), .ifq_valid(ifq_valid), .ifq_rd(ifq_rd),
    .dec_queue_sel(dec_queue_sel), .dec_reg_write(dec_reg_write),
    .dec_branch(dec_branch), .dec_jalr(dec_jalr),
    .rd(rd), .rs1(rs1), .rs2(rs2), .queue_full(queue_full), .queue_en(queue_en),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_tag_valid(rs1_tag_valid), .rs2_tag_valid(rs2_tag_valid),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rd_tag(rd_tag), .rd_tag_valid(rd_tag_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_branch(cdb_branch), .cdb_jalr(cdb_jalr),
    .rf_we(rf_we), .rf_rd(rf_rd), .free_count(free_count),
    .ctrl_wait(ctrl_wait), .fl_overflow(fl_overflow)
  );

  always #5 clk = ~clk;

  localparam int S_IFQ_RD = 0,  S_QEN   = 1,  S_RDTAG = 2,  S_RDTV  = 3;
  localparam int S_RS1TAG = 4,  S_RS1TV = 5,  S_RS2TV = 6,  S_RS1FWD = 7;
  localparam int S_RS2FWD = 8,  S_RFWE  = 9,  S_RFRD  = 10, S_FC    = 11;
  localparam int S_WAIT   = 12, S_OVF   = 13;

  localparam logic [3:0] QS_INT  = 4'(1 << Q_INT);
  localparam logic [3:0] QS_MULT = 4'(1 << Q_MULT);

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_IFQ_RD: return 32'(ifq_rd);
      S_QEN:    return 32'(queue_en);
      S_RDTAG:  return 32'(rd_tag);
      S_RDTV:   return 32'(rd_tag_valid);
      S_RS1TAG: return 32'(rs1_tag);
      S_RS1TV:  return 32'(rs1_tag_valid);
      S_RS2TV:  return 32'(rs2_tag_valid);
      S_RS1FWD: return 32'(rs1_fwd);
      S_RS2FWD: return 32'(rs2_fwd);
      S_RFWE:   return 32'(rf_we);
      S_RFRD:   return 32'(rf_rd);
      S_FC:     return 32'(free_count);
      S_WAIT:   return 32'(ctrl_wait);
      S_OVF:    return 32'(fl_overflow);
      default:  return 'x;
    endcase
  endfunction

  task automatic ex(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then advance past the next edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifq_valid = 0; dec_queue_sel = 0; dec_reg_write = 0; dec_branch = 0;
    dec_jalr = 0; rd = 0; rs1 = 0; rs2 = 0; queue_full = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_branch = 0; cdb_jalr = 0;
  endtask

  task automatic instr(input logic [3:0] sel, input logic w, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2);
    ifq_valid = 1; dec_queue_sel = sel; dec_reg_write = w;
    rd = d; rs1 = s1; rs2 = s2;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    cycle();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Strobes held low during reset even with a dispatchable head.
    rst = 1;
    idle();
    instr(QS_INT, 1, 5'd5, 5'd1, 5'd2);
    cycle();
    ex("rst_ifq_rd", S_IFQ_RD, 0);
    ex("rst_qen",    S_QEN,    0);
    ex("rst_rdtv",   S_RDTV,   0);
    cycle();
    rst = 0;
    idle();
    ex("rst_fc",   S_FC,   64);
    ex("rst_wait", S_WAIT, 0);
    ex("rst_ovf",  S_OVF,  0);
    cycle();

    // x5 = x1 + x2 to the int queue
    instr(QS_INT, 1, 5'd5, 5'd1, 5'd2);
    ex("add_ifq_rd", S_IFQ_RD, 1);
    ex("add_qen",    S_QEN,    4'b0001);
    ex("add_rdtag",  S_RDTAG,  0);
    ex("add_rdtv",   S_RDTV,   1);
    ex("add_rs1tv",  S_RS1TV,  0);
    ex("add_fc",     S_FC,     64);
    cycle();
    idle(); rs1 = 5;
    ex("x5_tv",  S_RS1TV,  1);
    ex("x5_tag", S_RS1TAG, 0);
    ex("x5_fc",  S_FC,     63);
    cycle();

    // CDB clears x5 and forwards to rs1 only
    idle(); rs1 = 5; rs2 = 1; cdb_valid = 1; cdb_tag = 0;
    ex("cdb_rfwe",  S_RFWE,   1);
    ex("cdb_rfrd",  S_RFRD,   5);
    ex("cdb_fwd1",  S_RS1FWD, 1);
    ex("cdb_fwd2",  S_RS2FWD, 0);
    cycle();
    idle(); rs1 = 5;
    ex("clr_tv",   S_RS1TV, 0);
    ex("clr_rfwe", S_RFWE,  0);
    ex("clr_fc",   S_FC,    64);
    cycle();

    // Back-pressure on the mult queue
    instr(QS_MULT, 1, 5'd6, 5'd0, 5'd0); queue_full = 4'b0010;
    ex("full_ifq_rd", S_IFQ_RD, 0);
    ex("full_qen",    S_QEN,    0);
    ex("full_rdtv",   S_RDTV,   0);
    ex("full_rdtag",  S_RDTAG,  1);
    cycle();
    queue_full = 0;
    ex("rel_ifq_rd", S_IFQ_RD, 1);
    ex("rel_qen",    S_QEN,    4'b0010);
    ex("rel_rdtag",  S_RDTAG,  1);
    ex("rel_rdtv",   S_RDTV,   1);
    cycle();

    // Branch stall
    idle(); instr(QS_INT, 0, 5'd0, 5'd1, 5'd2); dec_branch = 1;
    ex("br_ifq_rd", S_IFQ_RD, 1);
    ex("br_rdtv",   S_RDTV,   0);
    ex("br_wait",   S_WAIT,   0);
    cycle();
    idle(); instr(QS_INT, 1, 5'd7, 5'd0, 5'd0);
    ex("hold_wait",   S_WAIT,   1);
    ex("hold_ifq_rd", S_IFQ_RD, 0);
    cycle();
    cdb_branch = 1;
    ex("resolve_ifq_rd", S_IFQ_RD, 0);
    ex("resolve_wait",   S_WAIT,   1);
    cycle();
    cdb_branch = 0;
    ex("resume_wait",   S_WAIT,   0);
    ex("resume_ifq_rd", S_IFQ_RD, 1);
    ex("resume_rdtag",  S_RDTAG,  2);
    cycle();

    // Mid-operation reset drops pending mappings and refills the free-list
    do_reset();
    idle(); rs1 = 6; rs2 = 7;
    ex("mrst_tv1", S_RS1TV, 0);
    ex("mrst_tv2", S_RS2TV, 0);
    ex("mrst_fc",  S_FC,    64);
    cycle();

    // Exhaust the free-list
    for (int i = 0; i < 64; i++) begin
      idle(); instr(QS_INT, 1, 5'((i % 31) + 1), 5'd0, 5'd0);
      ex($sformatf("exh_tag%0d", i), S_RDTAG, 32'(i));
      ex($sformatf("exh_fc%0d", i),  S_FC,    32'(64 - i));
      cycle();
    end
    idle(); instr(QS_INT, 1, 5'd9, 5'd0, 5'd0);
    ex("empty_ifq_rd", S_IFQ_RD, 0);
    ex("empty_qen",    S_QEN,    0);
    ex("empty_fc",     S_FC,     0);
    cycle();
    // Tag 7 was re-mapped away from x8 by a later rename, so nothing clears.
    cdb_valid = 1; cdb_tag = 6'd7;
    ex("push7_ifq_rd", S_IFQ_RD, 0);
    ex("push7_rfwe",   S_RFWE,   0);
    cycle();
    cdb_valid = 0;
    ex("wrap_ifq_rd", S_IFQ_RD, 1);
    ex("wrap_rdtag",  S_RDTAG,  7);
    ex("wrap_fc",     S_FC,     1);
    cycle();
    idle();
    ex("wrap_fc_after", S_FC, 0);
    cycle();

    // Push into a full list sets the sticky overflow
    do_reset();
    idle(); cdb_valid = 1; cdb_tag = 6'd3;
    ex("ovf_pre", S_OVF, 0);
    cycle();
    idle();
    ex("ovf_set", S_OVF, 1);
    ex("ovf_fc",  S_FC,  64);
    cycle();
    ex("ovf_sticky", S_OVF, 1);
    cycle();
    do_reset();
    ex("ovf_clr", S_OVF, 0);
    cycle();

    // Write to x0 dispatches without renaming
    instr(QS_INT, 1, 5'd0, 5'd0, 5'd0);
    ex("x0_qen",  S_QEN,  4'b0001);
    ex("x0_rdtv", S_RDTV, 0);
    cycle();
    idle();
    ex("x0_fc", S_FC, 64);
    cycle();

    // Same-cycle rename of x5 and CDB clear of its old tag
    instr(QS_INT, 1, 5'd5, 5'd0, 5'd0);
    ex("rn1_rdtag", S_RDTAG, 0);
    cycle();
    instr(QS_INT, 1, 5'd5, 5'd0, 5'd0); cdb_valid = 1; cdb_tag = 6'd0;
    ex("rn2_rdtag", S_RDTAG, 1);
    ex("rn2_rfwe",  S_RFWE,  1);
    ex("rn2_rfrd",  S_RFRD,  5);
    cycle();
    idle(); rs1 = 5;
    ex("rn_tv",  S_RS1TV,  1);
    ex("rn_tag", S_RS1TAG, 1);
    ex("rn_fc",  S_FC,     63);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
